instr_executor: RTL and testbench

INSTR_EXECUTOR -- requirements
Module: instr_executor

---
 rtl/instr_register_pkg.sv | 35 +++
 rtl/instr_alu.sv | 44 ++++
 rtl/instr_executor.sv | 116 +++++++++++
 tb/tb_instr_executor.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared types for the instruction register and executor
// Contents: opcode_t, operand_t, address_t, instruction_t, result_t, exec_state_t.
package instr_register_pkg;

    // Encodings 8..15 are undefined and evaluate to a zero result.
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic        [4:0]  address_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } exec_state_t;

endpackage

// File: rtl/instr_alu.sv
// rtl/instr_alu.sv - combinational signed arithmetic for one instruction
// Ports:
//   instr    : instruction to evaluate (opcode, operand_a, operand_b)
//   result   : signed 64-bit result
//   div_zero : DIV/MOD attempted with operand_b == 0 (result forced to 0)
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      result,
    output logic         div_zero
);

    // Operands are widened first so that the sum, difference and product are
    // exact and so that -2^31 / -1 yields +2^31 instead of wrapping.
    result_t a64;
    result_t b64;

    assign a64 = {{32{instr.op_a[31]}}, instr.op_a};
    assign b64 = {{32{instr.op_b[31]}}, instr.op_b};

    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (instr.opc)
            ZERO:  result = '0;
            PASSA: result = a64;
            PASSB: result = b64;
            ADD:   result = a64 + b64;
            SUB:   result = a64 - b64;
            MULT:  result = a64 * b64;
            DIV: begin
                if (instr.op_b == '0) div_zero = 1'b1;
                else                  result   = a64 / b64;
            end
            MOD: begin
                if (instr.op_b == '0) div_zero = 1'b1;
                else                  result   = a64 % b64;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_executor.sv
// rtl/instr_executor.sv - sequencer that executes a batch of instructions from the instruction register
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : one-cycle batch request (ignored while busy)
//   start_addr          : first entry of the batch, sampled with start
//   num_instr           : batch length 0..32 (larger values clamp to 32)
//   read_pointer        : instruction register read address
//   instruction_word    : combinational read data at read_pointer
//   result, result_index, result_div_zero, result_valid, result_ready : result handshake
//   busy                : high whenever not IDLE
//   done                : one-cycle pulse at batch completion
module instr_executor
    import instr_register_pkg::*;
#(
    parameter int NUM_ENTRIES = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     start_addr,
    input  logic [5:0]   num_instr,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output result_t      result,
    output address_t     result_index,
    output logic         result_div_zero,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         busy,
    output logic         done
);

    exec_state_t  state_q, state_d;
    address_t     index_q;
    address_t     rp_q;
    logic [5:0]   remaining_q;
    logic [5:0]   count;
    instruction_t instr_q;
    result_t      result_q;
    logic         dz_q;
    result_t      alu_result;
    logic         alu_div_zero;
    logic         handshake;

    assign count     = (num_instr > 6'(NUM_ENTRIES)) ? 6'(NUM_ENTRIES) : num_instr;
    assign handshake = (state_q == OUT) && result_ready;

    instr_alu u_alu (
        .instr    (instr_q),
        .result   (alu_result),
        .div_zero (alu_div_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (count == '0) ? DONE : FETCH;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = OUT;
            OUT:     if (result_ready) state_d = (remaining_q == 6'd1) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rp_q is loaded on the way into FETCH, so it equals the index register
    // during FETCH and simply holds in every other state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_q     <= '0;
            rp_q        <= '0;
            remaining_q <= '0;
            instr_q     <= '0;
            result_q    <= '0;
            dz_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && count != '0) begin
                        index_q     <= start_addr;
                        rp_q        <= start_addr;
                        remaining_q <= count;
                    end
                end
                FETCH: instr_q <= instruction_word;
                EXEC: begin
                    result_q <= alu_result;
                    dz_q     <= alu_div_zero;
                end
                OUT: begin
                    if (handshake && remaining_q != 6'd1) begin
                        // 5-bit address wraps 31 -> 0 naturally
                        index_q     <= index_q + 5'd1;
                        rp_q        <= index_q + 5'd1;
                        remaining_q <= remaining_q - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_pointer    = rp_q;
    assign result          = result_q;
    assign result_index    = index_q;
    assign result_div_zero = dz_q;
    assign result_valid    = (state_q == OUT);
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);

endmodule

// File: tb/tb_instr_executor.sv
// tb/tb_instr_executor.sv - self-checking bench for instr_executor
module tb_instr_executor;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     start_addr;
    logic [5:0]   num_instr;
    address_t     read_pointer;
    instruction_t instruction_word;
    result_t      result;
    address_t     result_index;
    logic         result_div_zero;
    logic         result_valid;
    logic         result_ready;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    instr_executor #(.NUM_ENTRIES(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .num_instr        (num_instr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result           (result),
        .result_index     (result_index),
        .result_div_zero  (result_div_zero),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .done             (done)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int done_count = 0;
    int hs_count = 0;

    typedef struct {
        address_t idx;
        longint   res;
        bit       dz;
    } exp_t;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    // Reference arithmetic straight from the opcode table.
    task automatic model_alu(input instruction_t i, output longint r, output bit dz);
        longint a;
        longint b;
        a  = longint'(i.op_a);
        b  = longint'(i.op_b);
        r  = 0;
        dz = 0;
        case (i.opc)
            PASSA: r = a;
            PASSB: r = b;
            ADD:   r = a + b;
            SUB:   r = a - b;
            MULT:  r = a * b;
            DIV:   if (b == 0) dz = 1; else r = a / b;
            MOD:   if (b == 0) dz = 1; else r = a % b;
            default: r = 0;
        endcase
    endtask

    task automatic push_batch(input int sa, input int n);
        exp_t e;
        int   cnt;
        cnt = (n > 32) ? 32 : n;
        for (int i = 0; i < cnt; i++) begin
            e.idx = address_t'((sa + i) % 32);
            model_alu(mem[e.idx], e.res, e.dz);
            exp_q.push_back(e);
        end
    endtask

    // Single compare process: whenever a result is offered it must match the
    // head of the expected queue; an accepted result retires that entry.
    always @(negedge clk) begin
        if (reset_n) begin
            if (done) done_count++;
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("result", result, exp_q[0].res);
                    check("result_index", longint'(result_index), longint'(exp_q[0].idx));
                    check("result_div_zero", longint'(result_div_zero), longint'(exp_q[0].dz));
                    if (result_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                    end
                end
            end
        end
    end

    function automatic operand_t rand_operand();
        case ($urandom_range(0, 5))
            0:       return operand_t'(0);
            1:       return operand_t'(32'h8000_0000);
            2:       return operand_t'(-1);
            default: return operand_t'($urandom);
        endcase
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            mem[i].opc  = opcode_t'(4'($urandom_range(0, 15)));
            mem[i].op_a = rand_operand();
            mem[i].op_b = rand_operand();
        end
    endtask

    // With ready held high, result k (1-based) is offered in cycle 3k after
    // the start cycle and done follows the last one, i.e. cycle 3n+1
    // (an empty batch gives done in cycle 1).
    task automatic run_batch(input int sa, input int n, input bit rand_ready, input bit noise);
        int exp_n;
        int d0;
        int h0;
        int t0;
        int done_cyc;
        int budget;
        exp_n    = (n > 32) ? 32 : n;
        d0       = done_count;
        h0       = hs_count;
        done_cyc = -1;
        budget   = 0;
        push_batch(sa, n);
        @(posedge clk); #1;
        start        = 1'b1;
        start_addr   = address_t'(sa);
        num_instr    = 6'(n);
        result_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        t0           = cyc;
        while (!((hs_count - h0) >= exp_n && done_cyc >= 0) && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
            start = 1'b0;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (noise && (hs_count - h0) < exp_n) begin
                start      = 1'($urandom_range(0, 1));
                start_addr = address_t'($urandom_range(0, 31));
                num_instr  = 6'($urandom_range(0, 63));
            end
            result_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        start        = 1'b0;
        result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("handshakes", hs_count - h0, exp_n);
        check("done_pulses", done_count - d0, 1);
        check("idle_after_batch", longint'(busy), 0);
        if (!rand_ready) check("done_cycle", done_cyc - t0, 3 * exp_n + 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint       lit_sweep [8];
        longint       r;
        bit           dz;
        int           w;
        int           d0;

        lit_sweep = '{0, -9, 4, -5, -13, -36, -2, -1};
        reset_n      = 1'b0;
        start        = 1'b0;
        start_addr   = '0;
        num_instr    = '0;
        result_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset state
        #12;
        check("rst_read_pointer", longint'(read_pointer), 0);
        check("rst_result", result, 0);
        check("rst_result_index", longint'(result_index), 0);
        check("rst_div_zero", longint'(result_div_zero), 0);
        check("rst_valid", longint'(result_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", longint'(busy), 0);

        // ADD with backpressure: result held for 4 stalled cycles
        mem[0] = instruction_t'{ADD, 32'sd5, -32'sd7};
        model_alu(mem[0], r, dz);
        check("model_add", r, -2);
        push_batch(0, 1);
        d0 = done_count;
        @(posedge clk); #1;
        start = 1'b1; start_addr = '0; num_instr = 6'd1; result_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!result_valid && w < 20) begin @(posedge clk); #1; w++; end
        check("add_valid_seen", longint'(result_valid), 1);
        for (int k = 0; k < 4; k++) begin
            check("add_hold_result", result, -2);
            check("add_hold_index", longint'(result_index), 0);
            @(posedge clk); #1;
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        check("add_done_pulse", longint'(done), 1);
        @(posedge clk); #1;
        check("add_done_single", longint'(done), 0);
        check("add_done_count", done_count - d0, 1);
        check("add_queue_empty", exp_q.size(), 0);

        // Opcode sweep a=-9, b=4
        for (int i = 0; i < 8; i++) mem[i] = instruction_t'{opcode_t'(4'(i)), -32'sd9, 32'sd4};
        for (int i = 0; i < 8; i++) begin
            model_alu(mem[i], r, dz);
            check("model_sweep", r, lit_sweep[i]);
        end
        run_batch(0, 8, 1'b0, 1'b0);

        // Divide by zero
        mem[3] = instruction_t'{DIV, 32'sd10, 32'sd0};
        mem[4] = instruction_t'{MOD, 32'sd10, 32'sd0};
        model_alu(mem[3], r, dz);
        check("model_div0_dz", longint'(dz), 1);
        check("model_div0_res", r, 0);
        run_batch(3, 2, 1'b0, 1'b0);

        // MULT extremes
        mem[9] = instruction_t'{MULT, operand_t'(32'h8000_0000), operand_t'(32'h8000_0000)};
        model_alu(mem[9], r, dz);
        check("model_mult_ext", r, 64'sd4611686018427387904);
        run_batch(9, 1, 1'b1, 1'b0);

        // Wrap, empty batch, clamped batch
        fill_random();
        run_batch(30, 4, 1'b0, 1'b0);
        run_batch(5, 0, 1'b0, 1'b0);
        run_batch(7, 40, 1'b0, 1'b0);

        // Randomized batches with random backpressure and ignored starts
        for (int t = 0; t < 20; t++) begin
            fill_random();
            run_batch(int'($urandom_range(0, 31)), int'($urandom_range(0, 40)),
                      1'($urandom_range(0, 1)), 1'b1);
        end

        // Reset while a result is being offered
        fill_random();
        push_batch(0, 5);
        d0 = done_count;
        @(posedge clk); #1;
        start = 1'b1; start_addr = '0; num_instr = 6'd5; result_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!result_valid && w < 20) begin @(posedge clk); #1; w++; end
        check("mid_valid_seen", longint'(result_valid), 1);
        reset_n = 1'b0;
        #1;
        check("mid_read_pointer", longint'(read_pointer), 0);
        check("mid_result", result, 0);
        check("mid_result_index", longint'(result_index), 0);
        check("mid_div_zero", longint'(result_div_zero), 0);
        check("mid_valid", longint'(result_valid), 0);
        check("mid_busy", longint'(busy), 0);
        check("mid_done", longint'(done), 0);
        exp_q.delete();
        result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("post_rst_busy", longint'(busy), 0);
            check("post_rst_valid", longint'(result_valid), 0);
        end
        check("post_rst_no_done", done_count - d0, 0);

        // Block still usable after the abandoned batch
        run_batch(2, 3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
